// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t    : fetch controller states
//   INST_ADDR_BUS    : instruction address width
//   INST_BUS         : instruction word width
//   ZERO_WORD        : all-zero instruction word
//   DEFAULT_RESET_PC : first fetch address after reset
package pc_fetch_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;

   localparam logic [INST_BUS-1:0]      ZERO_WORD        = 32'h0000_0000;
   localparam logic [INST_ADDR_BUS-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      FULL    = 3'd2,
      DISCARD = 3'd3,
      HALT    = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// Instruction-fetch stage. Owns the PC, keeps at most one request to
// instruction memory outstanding, and holds one fetched instruction in the
// IF/ID output slot.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stall               : downstream cannot take the slot this cycle
//   redirect/redirect_pc: one-cycle restart at a new address
//   imem_req/imem_addr  : fetch request and address to instruction memory
//   imem_ack/imem_rdata : response (may arrive in the request cycle)
//   if_pc/if_inst       : slot PC and instruction
//   if_valid/if_adel    : slot occupied / slot is an address-error entry
//   fetch_busy          : request pending without ack (stall request)
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_BUS-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [INST_ADDR_BUS-1:0] redirect_pc,
   output logic                     imem_req,
   output logic [INST_ADDR_BUS-1:0] imem_addr,
   input  logic                     imem_ack,
   input  logic [INST_BUS-1:0]      imem_rdata,
   output logic [INST_ADDR_BUS-1:0] if_pc,
   output logic [INST_BUS-1:0]      if_inst,
   output logic                     if_valid,
   output logic                     if_adel,
   output logic                     fetch_busy
);

   fetch_state_t state, state_nxt;

   logic [INST_ADDR_BUS-1:0] pc;
   logic [INST_ADDR_BUS-1:0] drop_addr;   // address of a request being thrown away

   // datapath controls from the next-state logic
   logic                     ld_fetch;    // slot <= {pc, rdata}
   logic                     ld_adel;     // slot <= {adel_addr, 0, adel}
   logic                     clr_valid;   // slot consumed or flushed
   logic                     pc_inc;
   logic                     pc_redir;
   logic                     save_drop;
   logic [INST_ADDR_BUS-1:0] adel_addr;
   logic                     redir_mis;

   assign redir_mis = (redirect_pc[1:0] != 2'b00);

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         drop_addr <= '0;
         if_pc     <= '0;
         if_inst   <= ZERO_WORD;
         if_valid  <= 1'b0;
         if_adel   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (pc_redir)    pc <= redirect_pc;
         else if (pc_inc) pc <= pc + 32'd4;   // modulo 2^32 wrap

         if (save_drop) drop_addr <= pc;

         if (ld_fetch) begin
            if_pc    <= pc;
            if_inst  <= imem_rdata;
            if_valid <= 1'b1;
            if_adel  <= 1'b0;
         end else if (ld_adel) begin
            if_pc    <= adel_addr;
            if_inst  <= ZERO_WORD;
            if_valid <= 1'b1;
            if_adel  <= 1'b1;
         end else if (clr_valid) begin
            if_valid <= 1'b0;
            if_adel  <= 1'b0;
         end
      end
   end

   // next-state and datapath control
   always_comb begin
      state_nxt = state;
      ld_fetch  = 1'b0;
      ld_adel   = 1'b0;
      clr_valid = 1'b0;
      pc_inc    = 1'b0;
      pc_redir  = 1'b0;
      save_drop = 1'b0;
      adel_addr = redirect;
      adel_addr = redirect ? redirect_pc : pc;

      if (redirect) begin
         pc_redir  = 1'b1;
         clr_valid = 1'b1;
         unique case (state)
            REQ, DISCARD: begin
               if (imem_ack) begin
                  // outstanding request completes now; its data is dropped
                  if (redir_mis) begin ld_adel = 1'b1; state_nxt = HALT; end
                  else           state_nxt = REQ;
               end else begin
                  // request still in flight: keep its address on the bus
                  if (state == REQ) save_drop = 1'b1;
                  state_nxt = DISCARD;
               end
            end
            default: begin
               if (redir_mis) begin ld_adel = 1'b1; state_nxt = HALT; end
               else           state_nxt = REQ;
            end
         endcase
      end else begin
         unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
               if (imem_ack) begin
                  ld_fetch  = 1'b1;
                  pc_inc    = 1'b1;
                  state_nxt = FULL;
               end
            end
            FULL: begin
               if (!stall) begin
                  if (imem_ack) begin
                     // consume and refill on the same edge
                     ld_fetch = 1'b1;
                     pc_inc   = 1'b1;
                  end else begin
                     clr_valid = 1'b1;
                     state_nxt = REQ;
                  end
               end
            end
            DISCARD: begin
               if (imem_ack) begin
                  // a misaligned target was parked in pc during the wait
                  if (pc[1:0] != 2'b00) begin ld_adel = 1'b1; state_nxt = HALT; end
                  else                  state_nxt = REQ;
               end
            end
            HALT: begin
               if (if_valid && !stall) clr_valid = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // memory interface outputs
   always_comb begin
      imem_req   = (state == REQ) || (state == DISCARD) ||
                   ((state == FULL) && !stall && !redirect);
      imem_addr  = (state == DISCARD) ? drop_addr : pc;
      fetch_busy = imem_req && !imem_ack;
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: per-cycle vectors of inputs and expected
// outputs, followed by a hand-written misaligned-redirect-during-discard run.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        rst, stall, redirect, imem_ack;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, if_valid, if_adel, fetch_busy;
   logic [31:0] imem_addr, if_pc, if_inst;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc),
      .if_inst(if_inst), .if_valid(if_valid), .if_adel(if_adel),
      .fetch_busy(fetch_busy)
   );

   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_busy, e_valid;
      logic [31:0] e_pc, e_inst;
      logic        e_adel;
   } vec_t;

   vec_t tbl[$];

   localparam logic [31:0] I0 = 32'h2400_0A00, I1 = 32'h2400_0A01,
                           I2 = 32'h2400_0A02, I3 = 32'h2400_0A03,
                           I4 = 32'h2400_0A04, I5 = 32'h2400_0A05,
                           I6 = 32'h2400_0A06, I7 = 32'h2400_0A07,
                           I8 = 32'h2400_0A08, I9 = 32'h2400_0A09,
                           IA = 32'h2400_0A0A, IB = 32'h2400_0A0B,
                           JUNK = 32'hDEAD_BEEF;

   function automatic vec_t v(logic r, logic s, logic rd, logic [31:0] rpc,
                              logic a, logic [31:0] d, logic q, logic [31:0] ad,
                              logic b, logic vl, logic [31:0] p, logic [31:0] in,
                              logic ae);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = rd; t.rpc = rpc; t.ack = a; t.rdata = d;
      t.e_req = q; t.e_addr = ad; t.e_busy = b; t.e_valid = vl;
      t.e_pc = p; t.e_inst = in; t.e_adel = ae;
      return t;
   endfunction

   // drive at negedge, check 1ns later (well away from posedge)
   task automatic apply(input vec_t t, input string name);
      @(negedge clk);
      rst = t.rst; stall = t.stall; redirect = t.redir; redirect_pc = t.rpc;
      imem_ack = t.ack; imem_rdata = t.rdata;
      #1;
      checks++;
      if (imem_req !== t.e_req || (t.e_req && imem_addr !== t.e_addr) ||
          fetch_busy !== t.e_busy || if_valid !== t.e_valid ||
          if_pc !== t.e_pc || if_inst !== t.e_inst || if_adel !== t.e_adel) begin
         failures++;
         $display("FAIL %s: got req=%b addr=%h busy=%b valid=%b pc=%h inst=%h adel=%b; want req=%b addr=%h busy=%b valid=%b pc=%h inst=%h adel=%b",
                  name, imem_req, imem_addr, fetch_busy, if_valid, if_pc, if_inst, if_adel,
                  t.e_req, t.e_addr, t.e_busy, t.e_valid, t.e_pc, t.e_inst, t.e_adel);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      repeat (2) @(posedge clk);

      //          rst s  rd rpc           ack rdata  req addr          busy vld pc            inst adel
      // reset, then zero-wait fetch
      tbl.push_back(v(1, 0, 0, 0,            0, 0,    0, 0,            0, 0, 0,            0,  0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    0, 0,            0, 0, 0,            0,  0));
      tbl.push_back(v(0, 0, 0, 0,            1, I0,   1, 32'hBFC00000, 0, 0, 0,            0,  0));
      tbl.push_back(v(0, 0, 0, 0,            1, I1,   1, 32'hBFC00004, 0, 1, 32'hBFC00000, I0, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, I2,   1, 32'hBFC00008, 0, 1, 32'hBFC00004, I1, 0));
      // two-cycle memory
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    1, 32'hBFC0000C, 1, 1, 32'hBFC00008, I2, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, I3,   1, 32'hBFC0000C, 0, 0, 32'hBFC00008, I2, 0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    1, 32'hBFC00010, 1, 1, 32'hBFC0000C, I3, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, I4,   1, 32'hBFC00010, 0, 0, 32'hBFC0000C, I3, 0));
      // stall 3 cycles with slot full, then release
      tbl.push_back(v(0, 1, 0, 0,            0, 0,    0, 0,            0, 1, 32'hBFC00010, I4, 0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0,    0, 0,            0, 1, 32'hBFC00010, I4, 0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0,    0, 0,            0, 1, 32'hBFC00010, I4, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, I5,   1, 32'hBFC00014, 0, 1, 32'hBFC00010, I4, 0));
      // redirect while a request is outstanding
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    1, 32'hBFC00018, 1, 1, 32'hBFC00014, I5, 0));
      tbl.push_back(v(0, 0, 1, 32'h00000100, 0, 0,    1, 32'hBFC00018, 1, 0, 32'hBFC00014, I5, 0));
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    1, 32'hBFC00018, 1, 0, 32'hBFC00014, I5, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, JUNK, 1, 32'hBFC00018, 0, 0, 32'hBFC00014, I5, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, I6,   1, 32'h00000100, 0, 0, 32'hBFC00014, I5, 0));
      // misaligned redirect (overrides stall) -> HALT
      tbl.push_back(v(0, 1, 1, 32'h00000102, 0, 0,    0, 0,            0, 1, 32'h00000100, I6, 0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0,    0, 0,            0, 1, 32'h00000102, 0,  1));
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    0, 0,            0, 1, 32'h00000102, 0,  1));
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    0, 0,            0, 0, 32'h00000102, 0,  0));
      tbl.push_back(v(0, 0, 1, 32'h80000180, 0, 0,    0, 0,            0, 0, 32'h00000102, 0,  0));
      tbl.push_back(v(0, 0, 0, 0,            1, I7,   1, 32'h80000180, 0, 0, 32'h00000102, 0,  0));
      // redirect from FULL, then redirect beating a same-cycle ack
      tbl.push_back(v(0, 0, 1, 32'h00000200, 0, 0,    0, 0,            0, 1, 32'h80000180, I7, 0));
      tbl.push_back(v(0, 0, 1, 32'h00000300, 1, JUNK, 1, 32'h00000200, 0, 0, 32'h80000180, I7, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, I8,   1, 32'h00000300, 0, 0, 32'h80000180, I7, 0));
      // reset mid-request, late ack ignored
      tbl.push_back(v(0, 0, 0, 0,            0, 0,    1, 32'h00000304, 1, 1, 32'h00000300, I8, 0));
      tbl.push_back(v(1, 0, 0, 0,            0, 0,    1, 32'h00000304, 1, 0, 32'h00000300, I8, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, JUNK, 0, 0,            0, 0, 0,            0,  0));
      tbl.push_back(v(0, 0, 0, 0,            1, I9,   1, 32'hBFC00000, 0, 0, 0,            0,  0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0,    0, 0,            0, 1, 32'hBFC00000, I9, 0));
      // pc wrap at top of address space
      tbl.push_back(v(0, 1, 1, 32'hFFFFFFFC, 0, 0,    0, 0,            0, 1, 32'hBFC00000, I9, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, IA,   1, 32'hFFFFFFFC, 0, 0, 32'hBFC00000, I9, 0));
      tbl.push_back(v(0, 0, 0, 0,            1, IB,   1, 32'h00000000, 0, 1, 32'hFFFFFFFC, IA, 0));
      tbl.push_back(v(0, 1, 0, 0,            0, 0,    0, 0,            0, 1, 32'h00000000, IB, 0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

      // misaligned redirect landing while a discard is pending
      apply(v(0, 0, 0, 0,            0, 0,    1, 32'h00000004, 1, 1, 32'h00000000, IB, 0), "dis_req");
      apply(v(0, 0, 1, 32'h00000500, 0, 0,    1, 32'h00000004, 1, 0, 32'h00000000, IB, 0), "dis_redir1");
      apply(v(0, 0, 1, 32'h00000041, 0, 0,    1, 32'h00000004, 1, 0, 32'h00000000, IB, 0), "dis_redir2");
      apply(v(0, 0, 0, 0,            1, JUNK, 1, 32'h00000004, 0, 0, 32'h00000000, IB, 0), "dis_ack");
      apply(v(0, 0, 0, 0,            0, 0,    0, 0,            0, 1, 32'h00000041, 0,  1), "dis_adel");
      apply(v(0, 0, 0, 0,            0, 0,    0, 0,            0, 0, 32'h00000041, 0,  0), "dis_halt");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
